// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide sequencer: one shift-add or restoring-divide bit per cycle.
// Latency XLEN+1 cycles (1 for divide-by-zero/overflow); holds result until out_ready, in_ready only in IDLE.
module mdu_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

  logic [1:0]      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]      r_f3;
  logic            r_neg;
  logic            r_rem_neg;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_result;

  logic            w_is_div;
  logic            w_s1_sgn;
  logic            w_s2_sgn;
  logic            w_n1;
  logic            w_n2;
  logic [XLEN-1:0] w_m1;
  logic [XLEN-1:0] w_m2;
  logic            w_div0;
  logic            w_ovf;
  logic [XLEN-1:0] w_special;
  logic            w_accept;

  // Signed operands are reduced to magnitudes up front; signs are re-applied on the final iteration.
  assign w_is_div = in_funct3[2];
  assign w_s1_sgn = w_is_div ? ~in_funct3[0] : (in_funct3[1:0] == 2'b01 || in_funct3[1:0] == 2'b10);
  assign w_s2_sgn = w_is_div ? ~in_funct3[0] : (in_funct3[1:0] == 2'b01);
  assign w_n1     = w_s1_sgn & in_rs1[XLEN-1];
  assign w_n2     = w_s2_sgn & in_rs2[XLEN-1];
  assign w_m1     = w_n1 ? -in_rs1 : in_rs1;
  assign w_m2     = w_n2 ? -in_rs2 : in_rs2;
  assign w_div0   = w_is_div && (in_rs2 == '0);
  assign w_ovf    = w_is_div && !in_funct3[0] && (in_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (in_rs2 == '1);
  assign w_accept = (r_state == S_IDLE) && in_valid && !flush;

  always_comb begin
    w_special = '0;
    if (w_div0)
      w_special = in_funct3[1] ? in_rs1 : '1;
    else if (!in_funct3[1])
      w_special = {1'b1, {(XLEN-1){1'b0}}};
  end

  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_shift;
  logic [XLEN:0]     w_diff;
  logic              w_qbit;
  logic [XLEN-1:0]   w_nhi;
  logic [XLEN-1:0]   w_nlo;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_final;

  // Multiply: {hi,lo} shifts right with lo holding the unconsumed multiplier bits.
  // Divide: remainder in hi, dividend shifts out of lo's top while quotient bits enter its bottom.
  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_shift = {r_hi, r_lo[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_b};
  assign w_qbit  = ~w_diff[XLEN];

  always_comb begin
    if (r_f3[2]) begin
      w_nhi = w_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
      w_nlo = {r_lo[XLEN-2:0], w_qbit};
    end else begin
      w_nhi = w_sum[XLEN:1];
      w_nlo = {w_sum[0], r_lo[XLEN-1:1]};
    end
  end

  assign w_prod = r_neg ? -{w_nhi, w_nlo} : {w_nhi, w_nlo};
  assign w_quo  = r_neg ? -w_nlo : w_nlo;
  assign w_rem  = r_rem_neg ? -w_nhi : w_nhi;

  always_comb begin
    if (r_f3[2])
      w_final = r_f3[1] ? w_rem : w_quo;
    else if (r_f3[1:0] == 2'b00)
      w_final = w_prod[XLEN-1:0];
    else
      w_final = w_prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_f3      <= '0;
      r_neg     <= 1'b0;
      r_rem_neg <= 1'b0;
      r_b       <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_result  <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_f3      <= in_funct3;
            r_cnt     <= '0;
            r_neg     <= w_n1 ^ w_n2;
            r_rem_neg <= w_n1;
            r_hi      <= '0;
            r_lo      <= w_is_div ? w_m1 : w_m2;
            r_b       <= w_is_div ? w_m2 : w_m1;
            if (w_div0 || w_ovf) begin
              r_result <= w_special;
              r_state  <= S_DONE;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_hi  <= w_nhi;
          r_lo  <= w_nlo;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_result <= w_final;
            r_cnt    <= '0;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_DONE);
  assign busy       = (r_state != S_IDLE);
  assign out_result = r_result;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: scoreboard of expected results/latencies popped when out_valid rises.
module tb_mdu_seq;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0]  in_funct3;
  logic [31:0] in_rs1, in_rs2, out_result;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];

  always #5 clk = ~clk;

  mdu_seq #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .busy(busy)
  );

  function automatic logic [31:0] ref_mdu(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, p;
    logic [63:0] up;
    int ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ia = a;
    ib = b;
    case (f3)
      3'd0: begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * $signed({32'b0, b}); return p[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && b == 0) return 1;
    if (f3[2] && !f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 33;
  endfunction

  // Drive one request for a single cycle (the accept edge) and record what must come back.
  task automatic send_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e, input int el);
    @(negedge clk);
    in_valid = 1'b1; in_funct3 = f3; in_rs1 = a; in_rs2 = b;
    exp_q.push_back(e);
    lat_q.push_back(el);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // lat counts clock edges from the accept edge (inclusive) to out_valid.
  task automatic wait_result(output int lat, output logic [31:0] res, output bit to);
    for (lat = 1; lat <= 100; lat++) begin
      if (out_valid) break;
      @(posedge clk); #1;
    end
    to  = !out_valid;
    res = out_result;
  endtask

  task automatic take_result;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_funct3 = '0; in_rs1 = '0; in_rs2 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL reset_out_result: got %h want 0", out_result); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
  endtask

  // Table of {funct3, rs1, rs2, expected result, expected latency} run back to back.
  task automatic run_table(input string name, input logic [2:0] f3s[], input logic [31:0] as[],
                           input logic [31:0] bs[], input logic [31:0] es[], input int ls[]);
    int lat; logic [31:0] res, e; int el; bit to;
    for (int i = 0; i < f3s.size(); i++) begin
      send_op(f3s[i], as[i], bs[i], es[i], ls[i]);
      wait_result(lat, res, to);
      e = exp_q.pop_front(); el = lat_q.pop_front();
      checks++;
      if (to || lat != el) begin
        errors++; $display("FAIL %s[%0d]_latency: got %0d want %0d", name, i, lat, el);
      end
      checks++;
      if (res !== e) begin
        errors++; $display("FAIL %s[%0d]_result: got %h want %h", name, i, res, e);
      end
      take_result;
    end
  endtask

  task automatic test_mul;
    run_table("mul", '{3'd0, 3'd1, 3'd3, 3'd2},
              '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF},
              '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF},
              '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF},
              '{33, 33, 33, 33});
  endtask

  task automatic test_div;
    run_table("div", '{3'd4, 3'd6, 3'd5, 3'd7},
              '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'd100},
              '{32'd2, 32'd2, 32'd2, 32'd7},
              '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'd2},
              '{33, 33, 33, 33});
  endtask

  task automatic test_special;
    run_table("special", '{3'd4, 3'd7, 3'd4, 3'd6},
              '{32'd5, 32'd5, 32'h80000000, 32'h80000000},
              '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF},
              '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0},
              '{1, 1, 1, 1});
  endtask

  task automatic test_random;
    logic [2:0] f3s[]; logic [31:0] as[], bs[], es[]; int ls[];
    f3s = new[8]; as = new[8]; bs = new[8]; es = new[8]; ls = new[8];
    for (int i = 0; i < 8; i++) begin
      f3s[i] = 3'(i);
      as[i]  = $urandom;
      bs[i]  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      es[i]  = ref_mdu(f3s[i], as[i], bs[i]);
      ls[i]  = ref_lat(f3s[i], as[i], bs[i]);
    end
    run_table("random", f3s, as, bs, es, ls);
  endtask

  task automatic test_back_to_back;
    int lat; logic [31:0] res, e; int el; bit to;
    send_op(3'd0, 32'd6, 32'd7, 32'd42, 33);
    wait_result(lat, res, to);
    checks++; if (to || lat != 33) begin errors++; $display("FAIL bp_first_latency: got %0d want 33", lat); end
    in_valid = 1'b1; in_funct3 = 3'd5; in_rs1 = 32'd1000; in_rs2 = 32'd10;
    exp_q.push_back(32'd100); lat_q.push_back(33);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, out_valid); end
      checks++; if (out_result !== exp_q[0]) begin errors++; $display("FAIL bp_hold_result[%0d]: got %h want %h", i, out_result, exp_q[0]); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_low[%0d]: got %b want 0", i, in_ready); end
    end
    e = exp_q.pop_front(); el = lat_q.pop_front();
    checks++; if (out_result !== e) begin errors++; $display("FAIL bp_first_result: got %h want %h", out_result, e); end
    take_result;
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL bp_release: in_ready=%b busy=%b want 1/0", in_ready, busy); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_second_accept: busy=%b want 1", busy); end
    wait_result(lat, res, to);
    e = exp_q.pop_front(); el = lat_q.pop_front();
    checks++; if (to || lat != el) begin errors++; $display("FAIL bp_second_latency: got %0d want %0d", lat, el); end
    checks++; if (res !== e) begin errors++; $display("FAIL bp_second_result: got %h want %h", res, e); end
    take_result;
  endtask

  task automatic test_flush;
    int lat; logic [31:0] res, e; int el; bit to, seen;
    send_op(3'd0, 32'd123, 32'd456, 32'd56088, 33);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    void'(exp_q.pop_front()); void'(lat_q.pop_front());
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL flush_idle: in_ready=%b busy=%b want 1/0", in_ready, busy); end
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_valid: out_valid seen=%b want 0", seen); end
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; in_funct3 = 3'd3; in_rs1 = 32'd9; in_rs2 = 32'd9;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_blocks_accept: busy=%b want 0", busy); end
    send_op(3'd3, 32'd3, 32'd5, 32'd0, 33);
    wait_result(lat, res, to);
    e = exp_q.pop_front(); el = lat_q.pop_front();
    checks++; if (to || lat != el) begin errors++; $display("FAIL flush_next_latency: got %0d want %0d", lat, el); end
    checks++; if (res !== e) begin errors++; $display("FAIL flush_next_result: got %h want %h", res, e); end
    take_result;
  endtask

  task automatic test_reset_in_done;
    int lat; logic [31:0] res, e; int el; bit to;
    send_op(3'd7, 32'd100, 32'd7, 32'd2, 33);
    wait_result(lat, res, to);
    e = exp_q.pop_front(); el = lat_q.pop_front();
    checks++; if (to || res !== e) begin errors++; $display("FAIL rst_done_result: got %h want %h", res, e); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_done_valid: got %b want 0", out_valid); end
    checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL rst_done_result_clr: got %h want 0", out_result); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_done_in_ready: got %b want 1", in_ready); end
  endtask

  initial begin
    test_reset;
    test_mul;
    test_div;
    test_special;
    test_random;
    test_back_to_back;
    test_flush;
    test_reset_in_done;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
